l1dcache_requester: RTL

- Client-side initiator for the L1 data cache core interface; it drives `en`/`enW`/`addr`/`mask`/`reqData` and consumes `nack`/`respData` one cycle later.
- Sits between the core's memory-uop issue stage and the L1 data cache.
- Converts byte-addressed, sized load/store uops into word-addressed, byte-masked cache accesses.
- Retries nacked accesses with linear backoff, then returns aligned, extended load data or a fault to the writeback stage.
- Non-pipelined: one uop in flight at a time.

---
 rtl/l1dcache_requester.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/l1dcache_requester.sv
// l1dcache_requester: issues one load/store uop at a time to the L1 data cache.
// It forms the word address, byte mask and lane-positioned store data for each access.
// Nacked accesses are retried with a linear backoff.
// Load data is aligned and extended before it is returned with the uop tag.
module l1dcache_requester #(
    parameter int ADDR_BITS   = 30,
    parameter int TAG_W       = 4,
    parameter int RETRY_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqIsStore,
    input  logic [ADDR_BITS+1:0] reqAddr,
    input  logic [1:0]           reqSize,
    input  logic                 reqSigned,
    input  logic [31:0]          reqData,
    input  logic [TAG_W-1:0]     reqTag,
    output logic                 respValid,
    input  logic                 respReady,
    output logic [31:0]          respData,
    output logic [TAG_W-1:0]     respTag,
    output logic [1:0]           respFault,
    output logic                 dcEn,
    output logic                 dcEnW,
    output logic [ADDR_BITS-1:0] dcAddr,
    output logic [3:0]           dcMask,
    output logic [31:0]          dcReqData,
    input  logic                 dcNack,
    input  logic [31:0]          dcRespData
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, BACKOFF, RESP} state_t;

    localparam logic [7:0] LIMIT = 8'(RETRY_LIMIT);

    state_t      state, state_nxt;
    logic [7:0]  retryCnt, backoffCnt;
    logic [7:0]  retry_inc;
    logic        uopStore, uopSigned;
    logic [1:0]  uopSize, uopOff;
    logic        accept, misaligned_req;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        misaligned = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_mask = 4'b0001 << off;
            2'd1:    lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Store data is truncated to its size first so lanes outside the mask carry zeros.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [1:0] off,
                                              input logic [31:0] data);
        logic [31:0] d;
        case (size)
            2'd0:    d = {24'b0, data[7:0]};
            2'd1:    d = {16'b0, data[15:0]};
            default: d = data;
        endcase
        lane_data = d << {off, 3'b000};
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic sgn,
                                                 input logic [1:0] off, input logic [31:0] word);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> {off, 3'b000};
        b  = signed'(sh[7:0]);
        h  = signed'(sh[15:0]);
        case (size)
            2'd0:    load_extract = sgn ? 32'(b) : {24'b0, sh[7:0]};
            2'd1:    load_extract = sgn ? 32'(h) : {16'b0, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    assign accept         = reqValid && (state == IDLE);
    assign misaligned_req = misaligned(reqSize, reqAddr[1:0]);
    assign retry_inc      = retryCnt + 8'd1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (reqValid) state_nxt = misaligned_req ? RESP : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (!dcNack || retry_inc == LIMIT) state_nxt = RESP;
                     else state_nxt = BACKOFF;
            BACKOFF: if (backoffCnt <= 8'd1) state_nxt = ISSUE;
            RESP:    if (respReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        reqReady  = (state == IDLE);
        dcEn      = (state == ISSUE);
        respValid = (state == RESP);
    end

    // Uop latch, cache request fields, retry counters and response fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retryCnt   <= 8'd0;
            backoffCnt <= 8'd0;
            uopStore   <= 1'b0;
            uopSigned  <= 1'b0;
            uopSize    <= 2'd0;
            uopOff     <= 2'd0;
            dcEnW      <= 1'b0;
            dcAddr     <= '0;
            dcMask     <= 4'd0;
            dcReqData  <= 32'd0;
            respData   <= 32'd0;
            respTag    <= '0;
            respFault  <= 2'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    retryCnt  <= 8'd0;
                    uopStore  <= reqIsStore;
                    uopSigned <= reqSigned;
                    uopSize   <= reqSize;
                    uopOff    <= reqAddr[1:0];
                    dcEnW     <= reqIsStore;
                    dcAddr    <= reqAddr[ADDR_BITS+1:2];
                    dcMask    <= lane_mask(reqSize, reqAddr[1:0]);
                    dcReqData <= lane_data(reqSize, reqAddr[1:0], reqData);
                    respTag   <= reqTag;
                    respData  <= 32'd0;
                    respFault <= misaligned_req ? 2'd1 : 2'd0;
                end
                WAIT: if (!dcNack) begin
                    respData  <= uopStore ? 32'd0 : load_extract(uopSize, uopSigned, uopOff, dcRespData);
                    respFault <= 2'd0;
                end else begin
                    retryCnt <= retry_inc;
                    if (retry_inc == LIMIT) begin
                        respData  <= 32'd0;
                        respFault <= 2'd2;
                    end else begin
                        backoffCnt <= retry_inc;
                    end
                end
                BACKOFF: backoffCnt <= backoffCnt - 8'd1;
                default: ;
            endcase
        end
    end

endmodule
